// File: rtl/dbg_ctrl_defs.sv
// Shared debug-controller definitions: FSM state encoding and default run divider.
package dbg_ctrl_defs;

    typedef enum logic {
        S_STEP = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEF_RUN_DIV = 1000;

endpackage

// File: rtl/step_ctrl_if.sv
// Key inputs and CPU-enable/status outputs of the step/run controller.
interface step_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             key_step;
    logic             key_mode;
    logic             cpu_en;
    logic             running;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        output key_step,
        output key_mode,
        input  cpu_en,
        input  running,
        input  step_cnt
    );

    modport slave (
        input  key_step,
        input  key_mode,
        output cpu_en,
        output running,
        output step_cnt
    );
endinterface

// File: rtl/edge_rise.sv
// One-flop rising-edge detector; prev reset value selects whether a key held
// through reset may count as a press.
module edge_rise #(
    parameter logic PREV_RST = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic rise_o
);
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev_q <= PREV_RST;
        else     prev_q <= key_i;
    end

    assign rise_o = key_i & ~prev_q;
endmodule

// File: rtl/step_ctrl.sv
// Single-step / run controller: turns debounced key presses into a CPU
// clock-enable and keeps a wrapping count of issued enables.
module step_ctrl
    import dbg_ctrl_defs::*;
#(
    parameter int unsigned RUN_DIV = DEF_RUN_DIV,
    parameter int unsigned NBITS   = 24,
    parameter int unsigned CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    step_ctrl_if.slave bus
);
    localparam logic [NBITS-1:0] DIV_LAST = NBITS'(RUN_DIV - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] div_q, div_d;
    logic             cpu_en_q, cpu_en_d;
    logic             running_q, running_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_press;
    logic             mode_press;
    logic             div_term;

    edge_rise #(.PREV_RST(1'b1)) u_step_edge (
        .clk    (clk),
        .rst    (rst),
        .key_i  (bus.key_step),
        .rise_o (step_press)
    );

    edge_rise #(.PREV_RST(1'b1)) u_mode_edge (
        .clk    (clk),
        .rst    (rst),
        .key_i  (bus.key_mode),
        .rise_o (mode_press)
    );

    assign div_term = (div_q == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_STEP;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (mode_press) begin
            state_d = (state_q == S_STEP) ? S_RUN : S_STEP;
        end
    end

    // A mode press overrides both the step pulse and a terminating divider.
    always_comb begin
        div_d     = '0;
        cpu_en_d  = 1'b0;
        running_d = (state_d == S_RUN);
        cnt_d     = cpu_en_q ? cnt_q + CNT_W'(1) : cnt_q;
        if (!mode_press) begin
            if (state_q == S_RUN) begin
                if (div_term) begin
                    cpu_en_d = 1'b1;
                end else begin
                    div_d = div_q + NBITS'(1);
                end
            end else begin
                cpu_en_d = step_press;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            div_q     <= div_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.cpu_en   = cpu_en_q;
    assign bus.running  = running_q;
    assign bus.step_cnt = cnt_q;
endmodule

// File: tb/tb_step_ctrl.sv
// Directed self-checking bench for step_ctrl: one DUT with RUN_DIV=4, one with
// RUN_DIV=1 and a 4-bit counter.
module tb_step_ctrl;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_tests;
    int   n_fail;

    step_ctrl_if #(.CNT_W(16)) bus_a ();
    step_ctrl_if #(.CNT_W(4))  bus_b ();

    step_ctrl #(.RUN_DIV(4), .NBITS(24), .CNT_W(16)) u_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    step_ctrl #(.RUN_DIV(1), .NBITS(24), .CNT_W(4)) u_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_a.key_step = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (bus_a.cpu_en !== 1'b0 || bus_a.running !== 1'b0 || bus_a.step_cnt !== 16'd0) begin
            $display("FAIL reset_vals: cpu_en=%b running=%b cnt=%0d want 0 0 0",
                     bus_a.cpu_en, bus_a.running, bus_a.step_cnt);
            n_fail++;
        end
        rst_a = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_tests++;
            if (bus_a.cpu_en !== 1'b0) begin
                $display("FAIL held_key cyc%0d: cpu_en=%b want 0", i, bus_a.cpu_en);
                n_fail++;
            end
        end
        n_tests++;
        if (bus_a.step_cnt !== 16'd0) begin
            $display("FAIL held_key_cnt: cnt=%0d want 0", bus_a.step_cnt);
            n_fail++;
        end
    endtask

    task automatic test_step();
        bus_a.key_step = 1'b0;
        repeat (3) tick();
        for (int p = 0; p < 3; p++) begin
            bus_a.key_step = 1'b1;
            tick();
            n_tests++;
            if (bus_a.cpu_en !== 1'b1) begin
                $display("FAIL step_pulse%0d: cpu_en=%b want 1", p, bus_a.cpu_en);
                n_fail++;
            end
            for (int i = 0; i < 9; i++) begin
                if (i == 4) bus_a.key_step = 1'b0;
                tick();
                n_tests++;
                if (bus_a.cpu_en !== 1'b0) begin
                    $display("FAIL step_hold%0d cyc%0d: cpu_en=%b want 0", p, i, bus_a.cpu_en);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (bus_a.step_cnt !== 16'd3) begin
            $display("FAIL step_cnt: cnt=%0d want 3", bus_a.step_cnt);
            n_fail++;
        end
    endtask

    task automatic test_run();
        bus_a.key_mode = 1'b1;
        tick();
        n_tests++;
        if (bus_a.running !== 1'b1) begin
            $display("FAIL run_entry: running=%b want 1", bus_a.running);
            n_fail++;
        end
        bus_a.key_mode = 1'b0;
        for (int j = 1; j <= 23; j++) begin
            if (j == 6) bus_a.key_step = 1'b1;
            if (j == 8) bus_a.key_step = 1'b0;
            tick();
            n_tests++;
            if (bus_a.cpu_en !== ((j % 4) == 0 && j <= 20)) begin
                $display("FAIL run_cyc%0d: cpu_en=%b want %b", j, bus_a.cpu_en,
                         ((j % 4) == 0 && j <= 20));
                n_fail++;
            end
            if (j == 21) begin
                n_tests++;
                if (bus_a.step_cnt !== 16'd8) begin
                    $display("FAIL run_cnt: cnt=%0d want 8", bus_a.step_cnt);
                    n_fail++;
                end
            end
        end
        // Divider terminates on the same edge the mode press is sampled.
        bus_a.key_mode = 1'b1;
        tick();
        n_tests++;
        if (bus_a.running !== 1'b0 || bus_a.cpu_en !== 1'b0) begin
            $display("FAIL run_exit_term: running=%b cpu_en=%b want 0 0",
                     bus_a.running, bus_a.cpu_en);
            n_fail++;
        end
        bus_a.key_mode = 1'b0;
        repeat (6) tick();
        n_tests++;
        if (bus_a.cpu_en !== 1'b0 || bus_a.step_cnt !== 16'd8) begin
            $display("FAIL run_exit_idle: cpu_en=%b cnt=%0d want 0 8",
                     bus_a.cpu_en, bus_a.step_cnt);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        bus_a.key_step = 1'b1;
        bus_a.key_mode = 1'b1;
        tick();
        n_tests++;
        if (bus_a.running !== 1'b1 || bus_a.cpu_en !== 1'b0) begin
            $display("FAIL simul_press: running=%b cpu_en=%b want 1 0",
                     bus_a.running, bus_a.cpu_en);
            n_fail++;
        end
        bus_a.key_step = 1'b0;
        bus_a.key_mode = 1'b0;
        tick();
        bus_a.key_mode = 1'b1;
        tick();
        n_tests++;
        if (bus_a.running !== 1'b0 || bus_a.cpu_en !== 1'b0) begin
            $display("FAIL simul_exit: running=%b cpu_en=%b want 0 0",
                     bus_a.running, bus_a.cpu_en);
            n_fail++;
        end
        bus_a.key_mode = 1'b0;
        tick();
        bus_a.key_mode = 1'b1;
        tick();
        bus_a.key_mode = 1'b0;
        // A divider left non-zero by the early exit would pulse before cycle 4.
        for (int j = 1; j <= 4; j++) begin
            tick();
            n_tests++;
            if (bus_a.cpu_en !== (j == 4)) begin
                $display("FAIL div_clear cyc%0d: cpu_en=%b want %b", j, bus_a.cpu_en, (j == 4));
                n_fail++;
            end
        end
        bus_a.key_mode = 1'b1;
        tick();
        bus_a.key_mode = 1'b0;
        n_tests++;
        if (bus_a.running !== 1'b0 || bus_a.cpu_en !== 1'b0 || bus_a.step_cnt !== 16'd9) begin
            $display("FAIL simul_final: running=%b cpu_en=%b cnt=%0d want 0 0 9",
                     bus_a.running, bus_a.cpu_en, bus_a.step_cnt);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        rst_b = 1'b0;
        tick();
        bus_b.key_mode = 1'b1;
        tick();
        bus_b.key_mode = 1'b0;
        n_tests++;
        if (bus_b.running !== 1'b1 || bus_b.cpu_en !== 1'b0) begin
            $display("FAIL wrap_entry: running=%b cpu_en=%b want 1 0",
                     bus_b.running, bus_b.cpu_en);
            n_fail++;
        end
        for (int j = 1; j <= 17; j++) begin
            tick();
            n_tests++;
            if (bus_b.cpu_en !== 1'b1) begin
                $display("FAIL div1_cyc%0d: cpu_en=%b want 1", j, bus_b.cpu_en);
                n_fail++;
            end
            if (j == 16) begin
                n_tests++;
                if (bus_b.step_cnt !== 4'd15) begin
                    $display("FAIL wrap_pre: cnt=%0d want 15", bus_b.step_cnt);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (bus_b.step_cnt !== 4'd0) begin
            $display("FAIL wrap_zero: cnt=%0d want 0", bus_b.step_cnt);
            n_fail++;
        end
        bus_b.key_mode = 1'b1;
        tick();
        bus_b.key_mode = 1'b0;
        tick();
        n_tests++;
        if (bus_b.running !== 1'b0 || bus_b.cpu_en !== 1'b0 || bus_b.step_cnt !== 4'd1) begin
            $display("FAIL wrap_final: running=%b cpu_en=%b cnt=%0d want 0 0 1",
                     bus_b.running, bus_b.cpu_en, bus_b.step_cnt);
            n_fail++;
        end
    endtask

    task automatic test_async_reset();
        bus_b.key_mode = 1'b1;
        tick();
        bus_b.key_mode = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (bus_b.cpu_en !== 1'b1 || bus_b.running !== 1'b1 || bus_b.step_cnt !== 4'd5) begin
            $display("FAIL pre_reset: cpu_en=%b running=%b cnt=%0d want 1 1 5",
                     bus_b.cpu_en, bus_b.running, bus_b.step_cnt);
            n_fail++;
        end
        #3;
        rst_b = 1'b1;
        #1;
        n_tests++;
        if (bus_b.cpu_en !== 1'b0 || bus_b.running !== 1'b0 || bus_b.step_cnt !== 4'd0) begin
            $display("FAIL async_reset: cpu_en=%b running=%b cnt=%0d want 0 0 0",
                     bus_b.cpu_en, bus_b.running, bus_b.step_cnt);
            n_fail++;
        end
        bus_b.key_mode = 1'b1;
        #2;
        rst_b = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (bus_b.running !== 1'b0) begin
            $display("FAIL held_mode: running=%b want 0", bus_b.running);
            n_fail++;
        end
        bus_b.key_mode = 1'b0;
        tick();
        bus_b.key_mode = 1'b1;
        tick();
        bus_b.key_mode = 1'b0;
        n_tests++;
        if (bus_b.running !== 1'b1) begin
            $display("FAIL fresh_mode: running=%b want 1", bus_b.running);
            n_fail++;
        end
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst_a          = 1'b1;
        rst_b          = 1'b1;
        bus_a.key_step = 1'b0;
        bus_a.key_mode = 1'b0;
        bus_b.key_step = 1'b0;
        bus_b.key_mode = 1'b0;
        test_reset();
        test_step();
        test_run();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/step_ctrl.md
# step_ctrl

Single-step and run controller for the MIPS single-cycle board build. It sits directly downstream of the key debouncers and consumes their clean, `clk`-synchronous key levels. It turns button presses into a CPU clock-enable (`cpu_en`): exactly one pulse per press in step mode, or a periodic pulse in run mode. It also keeps a wrapping count of executed pulses for the seven-segment display.

## Interface
Parameters:
- `RUN_DIV`, default 24'd1000: period of `cpu_en` in run mode, in `clk` cycles. Legal range is 1 .. 2^NBITS-1.
- `NBITS`, default 24: width of the run-mode divider counter.
- `CNT_W`, default 16: width of `step_cnt`.

Ports:
- `clk`, input, 1: system clock; all logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `key_step`, input, 1: debounced step button level; 1 = pressed; synchronous to `clk`.
- `key_mode`, input, 1: debounced run/step toggle button level; synchronous to `clk`.
- `cpu_en`, output, 1: registered CPU clock-enable pulse.
- `running`, output, 1: registered; 1 = run mode, 0 = step mode.
- `step_cnt`, output, CNT_W: registered count of `cpu_en` pulses; wraps.

## Operation
- Inputs arrive already debounced and synchronised, so no extra synchroniser stages are added.
- Rising-edge detection:
  - Each key has a one-flop history register `prev`.
  - A press is `key & ~prev`.
  - `prev` resets to 1. A key held through reset therefore does not count as a press; a press needs a 0→1 transition after reset.
- States: `S_STEP` (reset state) and `S_RUN`.
- `S_STEP` behaviour:
  - A step press makes `cpu_en` 1 for exactly one cycle.
  - Holding the key does not repeat the pulse.
  - A mode press moves the block to `S_RUN`.
- `S_RUN` behaviour:
  - The divider `div` counts 0 .. RUN_DIV-1 and then wraps to 0.
  - `cpu_en` is 1 in the cycle after `div == RUN_DIV-1` is sampled.
  - A mode press moves the block to `S_STEP`.
  - Step presses are ignored.
- Mode and step press in the same cycle while in `S_STEP`: the mode press wins; there is no pulse and the block enters `S_RUN`.
- `div` is cleared to 0 on every state change, so the first run pulse comes RUN_DIV cycles after entry.
- Leaving `S_RUN` in the same cycle the divider terminates: no pulse is emitted.
- `RUN_DIV == 1`: `cpu_en` stays continuously high while in `S_RUN` from the second cycle onward.
- `step_cnt` increments by 1 in the cycle after each `cpu_en` high cycle and wraps from 2^CNT_W-1 to 0.
- `running` is 1 exactly while the state is `S_RUN`.

## Timing
- Reset values: `cpu_en` = 0, `running` = 0, `step_cnt` = 0, state = `S_STEP`, `div` = 0, both `prev` = 1.
- Step latency: `key_step` first sampled high at edge k (with `prev` = 0) → `cpu_en` high from edge k to edge k+1.
- Mode latency: `key_mode` press sampled at edge k → `running` changes at edge k.
- Run period: after entry at edge k, `cpu_en` is high during cycles k+RUN_DIV, k+2·RUN_DIV, …
- Pulse width: `cpu_en` is never high for more than 1 cycle, except the `RUN_DIV == 1` case.
- Reset asserted mid-pulse or mid-run: all registers return to their reset values immediately, with no clock needed. After release, the next press is recognised only on a fresh 0→1 transition.

## Structure
- Shared package/header `dbg_ctrl_defs`: state constants `S_STEP` = 1'b0 and `S_RUN` = 1'b1, plus the default `RUN_DIV` value. The future display mux also uses these.
- Sub-module `edge_rise`: a one-flop rising-edge detector with a parameterised reset value of `prev`. It is instantiated twice, once for `key_step` and once for `key_mode`.
- Top level contains the state register, divider, `cpu_en` register and `step_cnt` register.

## Test plan
- **Reset with held key.** Hold `key_step` = 1 through reset release, then keep it held 20 cycles → `cpu_en` stays 0 and `step_cnt` = 0.
- **Step presses.** Apply 3 separate step presses, each 5 cycles high and 5 cycles low → exactly 3 single-cycle `cpu_en` pulses, each 1 cycle after its press, and `step_cnt` = 3.
- **Run mode.** With RUN_DIV = 4: one mode press, then run 20 cycles → `running` = 1, `cpu_en` high at entry+4, +8, +12, +16, +20, and `step_cnt` = 5. A step press during this window is ignored.
- **Simultaneous presses.** In `S_STEP`, press step and mode in the same cycle → no pulse and `running` = 1. A second mode press → `running` = 0 and `div` is cleared.
- **Wrap.** With CNT_W = 4, issue 17 pulses → `step_cnt` = 1.
- **Async reset mid-run.** With RUN_DIV = 1, assert `rst` between clock edges → `cpu_en`, `running` and `step_cnt` all go to 0 before the next edge.
